fetch_queue_mw: RTL and testbench
=================================

Name: fetch_queue_mw

Overview:
- Parametrised successor to the dual-issue fetch queue. Buffers FETCH_W-wide prefetch groups until their ICache data returns, then presents up to ISSUE_W in-order instructions to decode.
- New behaviour:
  - depth, fetch width and issue width are parameters;
  - partial issue of a complete prefix;
  - up to MAX_OUT outstanding ICache requests, with exact cancel accounting across flush.
- Sits between the prefetch stage / ICache and the decode stage.

Parameters:
- DEPTH, 16: queue entries; power of two, at least 2*FETCH_W.
- FETCH_W, 2: instructions per prefetch group / ICache response.
- ISSUE_W, 2: decode lanes; at most DEPTH.
- MAX_OUT, 4: maximum outstanding ICache requests.
- EXC_W, 8: per-instruction exception field width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  pipeline flush; empties the queue.
- in_valid  in  1  prefetch group offered.
- in_ready  out  1  free slots >= FETCH_W.
- in_lane_valid  in  FETCH_W  per-slot valid; 0 = bubble.
- in_pc  in  FETCH_W*32  slot PCs; lane 0 in the LSBs.
- in_exc  in  FETCH_W*EXC_W  slot exception codes.
- icache_addr_ok  in  1  ICache accepted one request this cycle.
- icache_data_ok  in  1  one FETCH_W-wide response this cycle.
- icache_rdata  in  FETCH_W*32  response instructions.
- ds_allowin  in  1  decode accepts this cycle.
- out_valid  out  ISSUE_W  per-lane instruction valid.
- out_pc  out  ISSUE_W*32  lane PCs.
- out_inst  out  ISSUE_W*32  lane instructions.
- out_exc  out  ISSUE_W*EXC_W  lane exception codes.
- out_num  out  $clog2(ISSUE_W+1)  entries consumed on acceptance, bubbles included.
- pending_num  out  $clog2(MAX_OUT+1)  live outstanding requests; for prefetch throttling.

Behaviour:
- Entry fields: valid, complete, pc, exc, inst.
- Pointers: head, tail, fill, each $clog2(DEPTH) bits, wrapping modulo DEPTH. Occupancy count is $clog2(DEPTH)+1 bits.
- Reset: all entries cleared; head/tail/fill=0; count=0; pending=0; cancel=0.
  - Resulting outputs: out_valid=0, out_num=0, in_ready=1, pending_num=0.
- Enqueue:
  - Fires when in_valid && in_ready.
  - Writes FETCH_W consecutive slots from tail: valid=in_lane_valid[i], complete=0.
  - tail += FETCH_W.
  - Bubbles occupy slots so responses stay aligned.
- Fill:
  - Fires when icache_data_ok && cancel==0.
  - Slots fill..fill+FETCH_W-1 get inst=rdata lane i, complete=1.
  - fill += FETCH_W.
  - data_ok with fill==tail and cancel==0 is a protocol error; flag it with an assertion, state unchanged.
- Issue window: the first ISSUE_W slots from head.
  - k = length of the complete prefix within the window, counting only occupied slots.
  - out_valid[i] = (i<k) && slot.valid. out_pc/inst/exc come from slot head+i.
  - out_num = k, combinational.
  - With ds_allowin: head += k, count -= k. Bubbles are consumed silently. k=0 means no change.
- Count update: count_next = count + (enq ? FETCH_W : 0) - (deq ? k : 0).
  - Simultaneous enqueue and dequeue are legal at full occupancy only if in_ready held at the start of the cycle.
- pending: +1 on addr_ok, -1 on a live data_ok; both in one cycle leaves it unchanged.
  - Exceeding MAX_OUT is an assertion failure.
- Flush (dominates enqueue, fill and dequeue in the same cycle):
  - Clear all entry valid/complete; head=tail=fill=0; count=0.
  - cancel <= cancel + pending + addr_ok - data_ok, then pending <= 0.
  - A response arriving in the flush cycle is discarded.
  - Any request accepted in the flush cycle is also cancelled.
- Cancel: while cancel>0, each data_ok decrements cancel and writes nothing. A flush during cancel accumulates per the rule above.
- Reset mid-operation clears everything, including cancel. The ICache is reset in the same cycle.
- Outputs are combinational from registered state. Same-cycle fill or enqueue is not visible until the next cycle (1-cycle fill-to-issue latency).

Decomposition:
- Shared cpu package:
  - fetch_queue_mw_entry_t (valid, complete, pc, exc[EXC_W], inst);
  - the entry is parametrised by a localparam EXC_W mirrored in the package.
- One sub-module, fetch_cancel_ctr: owns pending/cancel counting and outputs the live-data qualifier. Reusable by the data-side refill path.

Test Plan:
- Single group: enqueue PC 0x1000/0x1004, addr_ok, data_ok 2 cycles later with 0x24010001/0x24020002.
  - Expect out_valid=2'b11 on the next cycle, with the PCs and instructions matching.
  - With ds_allowin: head=2, count=0.
- Bubble: in_lane_valid=2'b10 at PC 0x2000/0x2004, then filled.
  - Expect out_valid=2'b10 and out_num=2; slot 0 is consumed silently.
- Full/wrap, DEPTH=4, FETCH_W=2:
  - Two groups enqueued gives in_ready=0.
  - Fill, then dequeue with ds_allowin gives in_ready=1.
  - A third group lands in slots 0/1 after wrap, with correct data order.
- Partial issue, FETCH_W=2, ISSUE_W=4: only the first group filled.
  - Expect out_valid=4'b0011 and out_num=2.
- Flush with 3 outstanding plus addr_ok in the flush cycle: cancel=4.
  - The next 4 data_ok are discarded.
  - The 5th fills a group enqueued after the flush at PC 0xBFC00380.
- Flush coincident with data_ok and pending=1: cancel=0.
  - The next data_ok is accepted as live.

Source files
------------

// File: rtl/fetch_queue_mw_pkg.sv
// Shared types for the multi-width fetch queue.
package fetch_queue_mw_pkg;

    localparam int EXC_W = 8;

    typedef struct packed {
        logic             valid;
        logic             complete;
        logic [31:0]      pc;
        logic [EXC_W-1:0] exc;
        logic [31:0]      inst;
    } fetch_queue_mw_entry_t;

endpackage

// File: rtl/fetch_cancel_ctr.sv
// Outstanding-request and cancel bookkeeping shared by instruction and data refill paths.
module fetch_cancel_ctr #(
    parameter int MAX_OUT = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           addr_ok,
    input  logic                           data_ok,
    output logic [$clog2(MAX_OUT+1)-1:0]   pending,
    output logic                           data_live
);

    localparam int PN_W = $clog2(MAX_OUT + 1);
    // Cancel may briefly hold a full window of dead requests plus a flush-cycle request.
    localparam int CW   = $clog2(2 * MAX_OUT + 2);

    logic [PN_W-1:0] pending_r;
    logic [CW-1:0]   cancel_r;

    // Responses owed to squashed requests are retired before any live one.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= {PN_W{1'b0}};
            cancel_r  <= {CW{1'b0}};
        end else if (flush) begin
            cancel_r  <= cancel_r + CW'(pending_r) + CW'(addr_ok) - CW'(data_ok);
            pending_r <= {PN_W{1'b0}};
        end else if (cancel_r != {CW{1'b0}}) begin
            cancel_r  <= cancel_r - CW'(data_ok);
            pending_r <= pending_r + PN_W'(addr_ok);
        end else begin
            pending_r <= pending_r + PN_W'(addr_ok) - PN_W'(data_ok);
        end
    end

    assign pending   = pending_r;
    assign data_live = data_ok && !flush && (cancel_r == {CW{1'b0}});

endmodule

// File: rtl/fetch_queue_mw_chk.sv
// Protocol checks for the fetch queue: no orphan responses, bounded outstanding count.
module fetch_queue_mw_chk #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         data_live,
    input  logic [CNT_W-1:0]             unfilled,
    input  logic [$clog2(MAX_OUT+1)-1:0] pending
);

    a_no_orphan_data: assert property (@(posedge clk) disable iff (reset)
        !(data_live && (unfilled == {CNT_W{1'b0}})));

    a_pending_bound: assert property (@(posedge clk) disable iff (reset)
        (32'(pending) <= MAX_OUT));

endmodule

// File: rtl/fetch_queue_mw.sv
// Fetch queue: buffers prefetch groups until ICache data arrives, issues complete in-order prefixes.
module fetch_queue_mw #(
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int MAX_OUT = 4,
    parameter int EXC_W   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [FETCH_W-1:0]             in_lane_valid,
    input  logic [FETCH_W*32-1:0]          in_pc,
    input  logic [FETCH_W*EXC_W-1:0]       in_exc,
    input  logic                           icache_addr_ok,
    input  logic                           icache_data_ok,
    input  logic [FETCH_W*32-1:0]          icache_rdata,
    input  logic                           ds_allowin,
    output logic [ISSUE_W-1:0]             out_valid,
    output logic [ISSUE_W*32-1:0]          out_pc,
    output logic [ISSUE_W*32-1:0]          out_inst,
    output logic [ISSUE_W*EXC_W-1:0]       out_exc,
    output logic [$clog2(ISSUE_W+1)-1:0]   out_num,
    output logic [$clog2(MAX_OUT+1)-1:0]   pending_num
);

    import fetch_queue_mw_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ON_W  = $clog2(ISSUE_W + 1);

    fetch_queue_mw_entry_t q_r [DEPTH];
    logic [PTR_W-1:0] head_r, tail_r, fill_r;
    logic [CNT_W-1:0] count_r, unfilled_r;
    logic [ON_W-1:0]  k_s;
    logic             enq_s, deq_s, fill_s, data_live_s;

    fetch_cancel_ctr #(.MAX_OUT(MAX_OUT)) u_cancel (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .addr_ok   (icache_addr_ok),
        .data_ok   (icache_data_ok),
        .pending   (pending_num),
        .data_live (data_live_s)
    );

    fetch_queue_mw_chk #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_chk (
        .clk       (clk),
        .reset     (reset),
        .data_live (data_live_s),
        .unfilled  (unfilled_r),
        .pending   (pending_num)
    );

    assign in_ready = ((CNT_W'(DEPTH) - count_r) >= CNT_W'(FETCH_W));
    assign enq_s    = in_valid && in_ready;
    assign deq_s    = ds_allowin && (k_s != {ON_W{1'b0}});
    assign fill_s   = data_live_s && (unfilled_r != {CNT_W{1'b0}});
    assign out_num  = k_s;

    // Issue window: longest complete prefix of occupied slots; bubbles count toward k.
    always_comb begin
        fetch_queue_mw_entry_t slot_v;
        logic run_v;
        slot_v    = '0;
        run_v     = 1'b1;
        k_s       = {ON_W{1'b0}};
        out_valid = {ISSUE_W{1'b0}};
        out_pc    = {(ISSUE_W*32){1'b0}};
        out_inst  = {(ISSUE_W*32){1'b0}};
        out_exc   = {(ISSUE_W*EXC_W){1'b0}};
        for (int i = 0; i < ISSUE_W; i++) begin
            slot_v = q_r[head_r + PTR_W'(i)];
            out_pc[i*32 +: 32]        = slot_v.pc;
            out_inst[i*32 +: 32]      = slot_v.inst;
            out_exc[i*EXC_W +: EXC_W] = slot_v.exc;
            if (run_v && (CNT_W'(i) < count_r) && slot_v.complete) begin
                k_s          = ON_W'(i + 1);
                out_valid[i] = slot_v.valid;
            end else begin
                run_v = 1'b0;
            end
        end
    end

    // Queue storage and pointers; flush wins over enqueue, fill and issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_r[i] <= '0;
            end
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            fill_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            unfilled_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_r[i].valid    <= 1'b0;
                q_r[i].complete <= 1'b0;
            end
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            fill_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            unfilled_r <= {CNT_W{1'b0}};
        end else begin
            if (enq_s) begin
                for (int i = 0; i < FETCH_W; i++) begin
                    q_r[tail_r + PTR_W'(i)].valid    <= in_lane_valid[i];
                    q_r[tail_r + PTR_W'(i)].complete <= 1'b0;
                    q_r[tail_r + PTR_W'(i)].pc       <= in_pc[i*32 +: 32];
                    q_r[tail_r + PTR_W'(i)].exc      <= in_exc[i*EXC_W +: EXC_W];
                end
                tail_r <= tail_r + PTR_W'(FETCH_W);
            end
            if (fill_s) begin
                for (int i = 0; i < FETCH_W; i++) begin
                    q_r[fill_r + PTR_W'(i)].inst     <= icache_rdata[i*32 +: 32];
                    q_r[fill_r + PTR_W'(i)].complete <= 1'b1;
                end
                fill_r <= fill_r + PTR_W'(FETCH_W);
            end
            if (deq_s) begin
                head_r <= head_r + PTR_W'(k_s);
            end
            count_r    <= count_r + (enq_s ? CNT_W'(FETCH_W) : {CNT_W{1'b0}})
                                  - (deq_s ? CNT_W'(k_s) : {CNT_W{1'b0}});
            unfilled_r <= unfilled_r + (enq_s ? CNT_W'(FETCH_W) : {CNT_W{1'b0}})
                                     - (fill_s ? CNT_W'(FETCH_W) : {CNT_W{1'b0}});
        end
    end

endmodule

// File: tb/tb_fetch_queue_mw.sv
// Scoreboard bench for fetch_queue_mw: queue-of-entries reference model, directed scenarios then random traffic.
module tb_fetch_queue_mw;

    localparam int DEPTH = 8;
    localparam int FW    = 2;
    localparam int IW    = 4;
    localparam int MO    = 4;
    localparam int EW    = 8;
    localparam int ON_W  = $clog2(IW + 1);
    localparam int PN_W  = $clog2(MO + 1);

    logic clk = 1'b0;
    logic reset = 1'b1, flush = 1'b0, in_valid = 1'b0;
    logic [FW-1:0] in_lane_valid = '0;
    logic [FW*32-1:0] in_pc = '0, icache_rdata = '0;
    logic [FW*EW-1:0] in_exc = '0;
    logic icache_addr_ok = 1'b0, icache_data_ok = 1'b0, ds_allowin = 1'b0;
    logic in_ready;
    logic [IW-1:0] out_valid;
    logic [IW*32-1:0] out_pc, out_inst;
    logic [IW*EW-1:0] out_exc;
    logic [ON_W-1:0] out_num;
    logic [PN_W-1:0] pending_num;

    fetch_queue_mw #(.DEPTH(DEPTH), .FETCH_W(FW), .ISSUE_W(IW), .MAX_OUT(MO), .EXC_W(EW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_pc(in_pc), .in_exc(in_exc),
        .icache_addr_ok(icache_addr_ok), .icache_data_ok(icache_data_ok), .icache_rdata(icache_rdata),
        .ds_allowin(ds_allowin), .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_exc(out_exc), .out_num(out_num), .pending_num(pending_num)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        bit          complete;
        logic [31:0] pc;
        logic [EW-1:0] exc;
        logic [31:0] inst;
    } m_ent_t;

    typedef struct {
        bit               rdy;
        int               pend;
        int               num;
        logic [IW-1:0]    vld;
        logic [IW*32-1:0] pc;
        logic [IW*32-1:0] inst;
        logic [IW*EW-1:0] exc;
    } exp_t;

    m_ent_t mq[$];      // occupied slots in program order, bubbles included
    bit     req_q[$];   // outstanding ICache requests, oldest first; 1 = still wanted
    exp_t   exp_q[$];
    bit     init = 1'b0;
    int     checks = 0, passed = 0;

    function automatic int m_nfilled();
        int n = 0;
        foreach (mq[i]) begin
            if (!mq[i].complete) return n;
            n++;
        end
        return n;
    endfunction

    function automatic int m_k();
        int n = m_nfilled();
        return (n < IW) ? n : IW;
    endfunction

    function automatic int m_live();
        int n = 0;
        foreach (req_q[i]) n += int'(req_q[i]);
        return n;
    endfunction

    // One clock of stimulus: record what the DUT must show now, then advance the model over the edge.
    task automatic step(input bit rst, input bit fl, input bit iv, input logic [FW-1:0] lv,
                        input logic [FW*32-1:0] pcs, input logic [FW*EW-1:0] ex, input bit ao,
                        input bit dok, input logic [FW*32-1:0] rd, input bit ds);
        exp_t e;
        int   k, nf;
        bit   rdy, live;
        @(negedge clk);
        reset = rst; flush = fl; in_valid = iv; in_lane_valid = lv; in_pc = pcs; in_exc = ex;
        icache_addr_ok = ao; icache_data_ok = dok; icache_rdata = rd; ds_allowin = ds;
        k   = m_k();
        rdy = (DEPTH - mq.size()) >= FW;
        if (init) begin
            e.rdy = rdy; e.pend = m_live(); e.num = k;
            e.vld = '0; e.pc = '0; e.inst = '0; e.exc = '0;
            for (int i = 0; i < k; i++) begin
                e.vld[i] = mq[i].valid;
                e.pc[i*32 +: 32] = mq[i].pc;
                e.inst[i*32 +: 32] = mq[i].inst;
                e.exc[i*EW +: EW] = mq[i].exc;
            end
            exp_q.push_back(e);
        end
        if (rst) begin
            mq.delete(); req_q.delete(); init = 1'b1;
        end else if (fl) begin
            mq.delete();
            if (dok && req_q.size() > 0) void'(req_q.pop_front());
            foreach (req_q[i]) req_q[i] = 1'b0;
            if (ao) req_q.push_back(1'b0);
        end else begin
            nf = m_nfilled();
            if (dok && req_q.size() > 0) begin
                live = req_q.pop_front();
                if (live) begin
                    for (int i = 0; i < FW; i++) begin
                        if (nf + i < mq.size()) begin
                            mq[nf+i].complete = 1'b1;
                            mq[nf+i].inst = rd[i*32 +: 32];
                        end
                    end
                end
            end
            if (ds) repeat (k) void'(mq.pop_front());
            if (iv && rdy) begin
                for (int i = 0; i < FW; i++) begin
                    m_ent_t n;
                    n.valid = lv[i]; n.complete = 1'b0; n.pc = pcs[i*32 +: 32];
                    n.exc = ex[i*EW +: EW]; n.inst = '0;
                    mq.push_back(n);
                end
            end
            if (ao) req_q.push_back(1'b1);
        end
    endtask

    // Directed helper: consecutive PCs from pc0, instructions i0 + lane*0x00010001.
    task automatic go(input bit fl, input bit iv, input logic [FW-1:0] lv, input logic [31:0] pc0,
                      input bit ao, input bit dok, input logic [31:0] i0, input bit ds);
        logic [FW*32-1:0] pcs, rd;
        logic [FW*EW-1:0] ex;
        for (int i = 0; i < FW; i++) begin
            pcs[i*32 +: 32] = pc0 + 32'(4 * i);
            rd[i*32 +: 32]  = i0 + 32'(i) * 32'h0001_0001;
            ex[i*EW +: EW]  = EW'($urandom);
        end
        step(1'b0, fl, iv, lv, pcs, ex, ao, dok, rd, ds);
    endtask

    // Monitor: compares every presented cycle of DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (in_ready !== e.rdy || int'(pending_num) != e.pend || int'(out_num) != e.num
                    || out_valid !== e.vld) begin
                    $display("FAIL status t=%0t got rdy=%0b pend=%0d num=%0d vld=%b want rdy=%0b pend=%0d num=%0d vld=%b",
                             $time, in_ready, pending_num, out_num, out_valid, e.rdy, e.pend, e.num, e.vld);
                end else begin
                    passed++;
                end
                if (e.num > 0) begin
                    checks++;
                    ok = 1'b1;
                    for (int i = 0; i < IW; i++) begin
                        if (i < e.num && e.vld[i]) begin
                            if (out_pc[i*32 +: 32] !== e.pc[i*32 +: 32] || out_inst[i*32 +: 32] !== e.inst[i*32 +: 32]
                                || out_exc[i*EW +: EW] !== e.exc[i*EW +: EW]) ok = 1'b0;
                        end
                    end
                    if (!ok) begin
                        $display("FAIL lanes t=%0t got pc=%h inst=%h exc=%h want pc=%h inst=%h exc=%h (vld=%b)",
                                 $time, out_pc, out_inst, out_exc, e.pc, e.inst, e.exc, e.vld);
                    end else begin
                        passed++;
                    end
                end
            end
        end
    end

    initial begin
        logic [FW*32-1:0] pcs, rd;
        logic [FW*EW-1:0] ex;
        bit fl, iv, ao, dok, ds, rst;
        int unf;
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        // single group, data two cycles after request
        go(0, 1, 2'b11, 32'h1000, 1, 0, 32'h0, 0);
        go(0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 0);
        go(0, 0, 2'b00, 32'h0, 0, 1, 32'h2401_0001, 0);
        go(0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 0);
        go(0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 1);
        go(0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 1);
        // bubble in lane 0
        go(0, 1, 2'b10, 32'h2000, 1, 0, 32'h0, 0);
        go(0, 0, 2'b00, 32'h0, 0, 1, 32'h3C01_0010, 0);
        go(0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 0);
        go(0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 1);
        // partial issue: only the first of two groups filled
        go(0, 1, 2'b11, 32'h3000, 1, 0, 32'h0, 0);
        go(0, 1, 2'b11, 32'h3008, 1, 1, 32'h1111_0000, 0);
        go(0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 0);
        go(0, 0, 2'b00, 32'h0, 0, 1, 32'h2222_0000, 0);
        go(0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 1);
        // fill to full, refused offer, drain and wrap
        for (int g = 0; g < DEPTH / FW; g++) go(0, 1, 2'b11, 32'h4000 + 32'(8 * g), 1, 0, 32'h0, 0);
        go(0, 1, 2'b11, 32'h4800, 0, 0, 32'h0, 0);
        for (int g = 0; g < DEPTH / FW; g++) go(0, 0, 2'b00, 32'h0, 0, 1, 32'h5000_0000 + 32'(g << 8), 0);
        go(0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 1);
        go(0, 1, 2'b11, 32'h5000, 1, 0, 32'h0, 1);
        go(0, 0, 2'b00, 32'h0, 0, 1, 32'h6600_0066, 0);
        go(0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 1);
        go(0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 1);
        // flush with three outstanding plus a request in the flush cycle
        go(0, 1, 2'b11, 32'h6000, 1, 0, 32'h0, 0);
        go(0, 1, 2'b11, 32'h6008, 1, 0, 32'h0, 0);
        go(0, 0, 2'b00, 32'h0, 1, 0, 32'h0, 0);
        go(1, 0, 2'b00, 32'h0, 1, 0, 32'h0, 0);
        go(0, 1, 2'b11, 32'hBFC0_0380, 1, 0, 32'h0, 0);
        for (int j = 0; j < 4; j++) go(0, 0, 2'b00, 32'h0, 0, 1, 32'hDEAD_0000 + 32'(j), 0);
        go(0, 0, 2'b00, 32'h0, 0, 1, 32'h4008_0000, 0);
        go(0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 0);
        go(0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 1);
        // flush coincident with the only outstanding response
        go(0, 1, 2'b11, 32'h7000, 1, 0, 32'h0, 0);
        go(1, 0, 2'b00, 32'h0, 0, 1, 32'hBAD0_0000, 0);
        go(0, 1, 2'b11, 32'h7100, 1, 0, 32'h0, 0);
        go(0, 0, 2'b00, 32'h0, 0, 1, 32'h7700_0001, 0);
        go(0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 1);
        // random traffic, legal per the model, with one mid-run reset
        for (int n = 0; n < 3000; n++) begin
            rst = (n == 1500);
            fl  = ($urandom_range(0, 39) == 0);
            iv  = ($urandom_range(0, 2) != 0);
            ds  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < FW; i++) begin
                pcs[i*32 +: 32] = $urandom;
                rd[i*32 +: 32]  = $urandom;
                ex[i*EW +: EW]  = EW'($urandom);
            end
            unf = mq.size() - m_nfilled();
            ao  = !rst && (req_q.size() < MO) && (m_live() < unf / FW) && ($urandom_range(0, 1) == 1);
            dok = !rst && (req_q.size() > 0) && (!req_q[0] || unf >= FW) && ($urandom_range(0, 1) == 1);
            step(rst, fl, iv, FW'($urandom), pcs, ex, ao, dok, rd, ds);
        end
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
